// File: rtl/pwm_audio_capture.sv
// PWM audio capture: synchronizes a 1-bit PWM stream, counts ones over
// 2^WIN_BITS-clock windows and queues each window count in a small FIFO.
//   clk, reset      : clock, asynchronous active-high reset
//   pwm_in, enable  : PWM input (async), integration enable
//   sample, sample_valid, sample_ready : FIFO head, non-empty, consumer accept
//   level, overflow, clr_ovf           : occupancy, sticky drop flag, clear
module pwm_audio_capture #(
  parameter int unsigned WIN_BITS = 8,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pwm_in,
  input  logic                         enable,
  output logic [WIN_BITS:0]            sample,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  input  logic                         clr_ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic                sync_q1;
  logic                s;
  logic [WIN_BITS-1:0] wcnt;
  logic [WIN_BITS:0]   acc;
  logic [WIN_BITS:0]   s_ext;
  logic [WIN_BITS:0]   push_data;
  logic                terminal;
  logic                push;

  logic [WIN_BITS:0]   mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                empty;
  logic                full;
  logic                pop;
  logic                wr_en;
  logic                drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      s       <= 1'b0;
    end else begin
      sync_q1 <= pwm_in;
      s       <= sync_q1;
    end
  end

  always_comb begin
    s_ext     = {{WIN_BITS{1'b0}}, s};
    terminal  = enable && (wcnt == '1);
    push      = terminal;
    push_data = acc + s_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
      acc  <= '0;
    end else if (!enable) begin
      wcnt <= '0;
      acc  <= '0;
    end else begin
      wcnt <= wcnt + 1'b1;
      acc  <= terminal ? '0 : push_data;
    end
  end

  always_comb begin
    empty        = (level == '0);
    full         = (level == LW'(DEPTH));
    pop          = !empty && sample_ready;
    // a full FIFO still accepts a push when the head leaves on the same edge
    wr_en        = push && (!full || pop);
    drop         = push && full && !pop;
    sample_valid = !empty;
    sample       = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !wr_en) begin
        level <= level - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_audio_capture.sv
module tb_pwm_audio_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic       enable;
  logic [4:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic [2:0] level;
  logic       overflow;
  logic       clr_ovf;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model: input latency line, current window, FIFO contents
  int lat_q[$];
  int win_q[$];
  int fq[$];
  bit m_ovf;
  int ph;

  pwm_audio_capture #(.WIN_BITS(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .enable(enable),
    .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  s_now;
    int  val;
    bit  pu, po, fu, dr;
    if (reset) begin
      lat_q = '{0, 0};
      win_q.delete();
      fq.delete();
      m_ovf = 1'b0;
      return;
    end
    s_now = lat_q.pop_front();
    lat_q.push_back(int'(pwm_in));
    pu  = 1'b0;
    val = 0;
    if (enable) begin
      win_q.push_back(s_now);
      if (win_q.size() == 16) begin
        val = win_q.sum();
        pu  = 1'b1;
        win_q.delete();
      end
    end else begin
      win_q.delete();
    end
    po = (fq.size() > 0) && sample_ready;
    fu = (fq.size() == 4);
    dr = pu && fu && !po;
    if (po) void'(fq.pop_front());
    if (pu && !dr) fq.push_back(val);
    if (dr) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  task automatic check_all();
    chk("valid", 32'(sample_valid), 32'(fq.size() > 0));
    chk("sample", 32'(sample), (fq.size() > 0) ? 32'(fq[0]) : 32'd0);
    chk("level", 32'(level), 32'(fq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b1; pwm_in = 1'b0; enable = 1'b0; sample_ready = 1'b0; clr_ovf = 1'b0;
    lat_q = '{0, 0};
    m_ovf = 1'b0;
    repeat (2) step();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    reset = 1'b0;

    // all-ones input, no consumer: fill then overflow
    pwm_in = 1'b1;
    repeat (3) step();
    enable = 1'b1;
    repeat (16) step();
    chk("t31_first", 32'(sample), 32'd16);
    repeat (48) step();
    chk("t31_level4", 32'(level), 32'd4);
    chk("t31_noovf", 32'(overflow), 32'd0);
    repeat (16) step();
    chk("t31_ovf", 32'(overflow), 32'd1);
    chk("t31_level_hold", 32'(level), 32'd4);

    // clear coincident with a dropping push, then clear alone
    repeat (15) step();
    clr_ovf = 1'b1;
    step();
    chk("t36_set_wins", 32'(overflow), 32'd1);
    step();
    chk("t36_clear", 32'(overflow), 32'd0);
    clr_ovf = 1'b0;

    // full FIFO with pop on the terminal cycle
    repeat (14) step();
    sample_ready = 1'b1;
    step();
    chk("t33_level", 32'(level), 32'd4);
    chk("t33_ovf", 32'(overflow), 32'd0);
    sample_ready = 1'b0;
    enable = 1'b0;
    sample_ready = 1'b1;
    repeat (5) step();
    chk("drain_empty", 32'(sample_valid), 32'd0);

    // 25% duty then all-zero input
    ph = 0;
    for (int i = 0; i < 3; i++) begin
      pwm_in = (ph % 4 == 0); ph++; step();
    end
    enable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pwm_in = (ph % 4 == 0); ph++; step();
      if (fq.size() > 0) chk("t32_duty", 32'(sample), 32'd4);
    end
    enable = 1'b0; pwm_in = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      if (fq.size() > 0) chk("t32_zero", 32'(sample), 32'd0);
    end
    enable = 1'b0;
    repeat (2) step();

    // enable glitch mid-window discards the partial count
    sample_ready = 1'b0; pwm_in = 1'b1;
    repeat (3) step();
    enable = 1'b1;
    repeat (8) step();
    enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (15) step();
    chk("t34_no_early", 32'(level), 32'd0);
    step();
    chk("t34_level", 32'(level), 32'd1);
    chk("t34_full_win", 32'(sample), 32'd16);
    enable = 1'b0; sample_ready = 1'b1;
    repeat (2) step();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      pwm_in       = ($urandom_range(0, 99) < 60);
      enable       = ($urandom_range(0, 99) < 95);
      sample_ready = ($urandom_range(0, 99) < 40);
      clr_ovf      = ($urandom_range(0, 99) < 3);
      step();
    end

    // async reset with three entries queued
    enable = 1'b0; sample_ready = 1'b1; clr_ovf = 1'b0;
    repeat (5) step();
    sample_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 200 && fq.size() != 3; i++) begin
      pwm_in = ($urandom_range(0, 1) == 1);
      step();
    end
    chk("t35_reach3", 32'(level), 32'd3);
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    model_edge();
    chk("t35_valid", 32'(sample_valid), 32'd0);
    chk("t35_level", 32'(level), 32'd0);
    chk("t35_ovf", 32'(overflow), 32'd0);
    chk("t35_sample", 32'(sample), 32'd0);
    step();
    reset = 1'b0; pwm_in = 1'b0;
    repeat (15) step();
    chk("t35_no_stale", 32'(level), 32'd0);
    step();
    chk("t35_new_level", 32'(level), 32'd1);
    chk("t35_new_sample", 32'(sample), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
